// File: rtl/tlc_pkg.sv
// Shared types and helpers for the parametrised highway/farm traffic light controller.
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_HG    = 3'd0,
        ST_HY    = 3'd1,
        ST_AR1   = 3'd2,
        ST_FG    = 3'd3,
        ST_FY    = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6
    } tlc_state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    typedef struct packed {
        logic [2:0] hwy;
        logic [2:0] farm;
    } tlc_lights_t;

    // Lamp pattern for a state; phase only matters while flashing.
    function automatic tlc_lights_t lights_of(tlc_state_e st, logic phase);
        tlc_lights_t l;
        l.hwy  = RED;
        l.farm = RED;
        case (st)
            ST_HG:    begin l.hwy = GRN; l.farm = RED; end
            ST_HY:    begin l.hwy = YEL; l.farm = RED; end
            ST_FG:    begin l.hwy = RED; l.farm = GRN; end
            ST_FY:    begin l.hwy = RED; l.farm = YEL; end
            ST_FLASH: begin
                l.hwy  = {1'b0, phase, 1'b0};
                l.farm = {phase, 2'b00};
            end
            default:  begin l.hwy = RED; l.farm = RED; end
        endcase
        return l;
    endfunction

    // Normal-cycle successor; FLASH leaves via its own path.
    function automatic tlc_state_e succ_of(tlc_state_e st);
        case (st)
            ST_HG:   return ST_HY;
            ST_HY:   return ST_AR1;
            ST_AR1:  return ST_FG;
            ST_FG:   return ST_FY;
            ST_FY:   return ST_AR2;
            default: return ST_HG;
        endcase
    endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Timer tick prescaler: one tick every PRESCALE enabled cycles, realigned by clr.
module tlc_tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    assign tick = ena && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (ena && (r_cnt == LAST))) begin
            r_cnt <= '0;
        end else if (ena) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tlc_param_ctrl.sv
// Parametrised two-road traffic light controller with all-red clearance,
// latched pedestrian walk phase and a flashing night/fault mode.
module tlc_param_ctrl
    import tlc_pkg::*;
#(
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned TW           = 8,
    parameter int unsigned HG_MIN_TICKS = 10,
    parameter int unsigned Y_TICKS      = 3,
    parameter int unsigned AR_TICKS     = 1,
    parameter int unsigned FG_TICKS     = 10,
    parameter int unsigned FLASH_TICKS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       car_req,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic [2:0] hwy_light,
    output logic [2:0] farm_light,
    output logic       walk,
    output logic [2:0] state_o
);

    function automatic bit ticks_bad(int unsigned n);
        return (n < 1) || (64'(n) >= (64'(1) << TW));
    endfunction

    if (PRESCALE < 1 || ticks_bad(HG_MIN_TICKS) || ticks_bad(Y_TICKS) ||
        ticks_bad(AR_TICKS) || ticks_bad(FG_TICKS) || ticks_bad(FLASH_TICKS)) begin : g_bad_param
        $fatal(1, "tlc_param_ctrl: tick parameter out of range for TW");
    end

    // Timer reload value (N-1) for the state being entered.
    function automatic logic [TW-1:0] load_of(tlc_state_e st);
        case (st)
            ST_HG:          return TW'(HG_MIN_TICKS - 1);
            ST_HY, ST_FY:   return TW'(Y_TICKS - 1);
            ST_AR1, ST_AR2: return TW'(AR_TICKS - 1);
            ST_FG:          return TW'(FG_TICKS - 1);
            default:        return TW'(FLASH_TICKS - 1);
        endcase
    endfunction

    tlc_state_e    r_state;
    logic [TW-1:0] r_timer;
    logic          r_phase;
    logic          r_req_pending;
    logic          r_ped_pending;
    logic          r_walk;
    tlc_lights_t   r_lights;

    tlc_state_e    w_state_nxt;
    tlc_state_e    w_succ;
    logic [TW-1:0] w_timer_nxt;
    logic          w_phase_nxt;
    logic          w_trans;
    logic          w_tick;
    logic          w_enter_fg;
    logic          w_walk_nxt;

    tlc_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (w_trans),
        .tick  (w_tick)
    );

    assign w_succ = succ_of(r_state);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_phase_nxt = r_phase;
        w_trans     = 1'b0;
        case (r_state)
            ST_HG, ST_HY, ST_AR1, ST_FG, ST_FY, ST_AR2: begin
                if (ena) begin
                    if (flash_en) begin
                        w_state_nxt = ST_FLASH;
                        w_timer_nxt = load_of(ST_FLASH);
                        w_phase_nxt = 1'b1;
                        w_trans     = 1'b1;
                    end else if (w_tick) begin
                        if (r_timer != '0) begin
                            w_timer_nxt = r_timer - TW'(1);
                        end else if (r_state != ST_HG || r_req_pending || r_ped_pending) begin
                            w_state_nxt = w_succ;
                            w_timer_nxt = load_of(w_succ);
                            w_trans     = 1'b1;
                        end
                    end
                end
            end
            ST_FLASH: begin
                if (ena) begin
                    if (!flash_en) begin
                        w_state_nxt = ST_AR2;
                        w_timer_nxt = load_of(ST_AR2);
                        w_trans     = 1'b1;
                    end else if (w_tick) begin
                        if (r_timer != '0) begin
                            w_timer_nxt = r_timer - TW'(1);
                        end else begin
                            w_phase_nxt = ~r_phase;
                            w_timer_nxt = load_of(ST_FLASH);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HG;
                w_timer_nxt = load_of(ST_HG);
                w_phase_nxt = 1'b0;
                w_trans     = 1'b1;
            end
        endcase
    end

    // Walk follows the pedestrian flag captured on FG entry and holds for all of FG.
    assign w_enter_fg = (w_state_nxt == ST_FG) && (r_state != ST_FG);
    assign w_walk_nxt = (w_state_nxt == ST_FG) ? (w_enter_fg ? r_ped_pending : r_walk) : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_HG;
            r_timer       <= load_of(ST_HG);
            r_phase       <= 1'b0;
            r_req_pending <= 1'b0;
            r_ped_pending <= 1'b0;
            r_walk        <= 1'b0;
            r_lights      <= lights_of(ST_HG, 1'b0);
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_phase       <= w_phase_nxt;
            r_req_pending <= car_req | (r_req_pending & ~w_enter_fg);
            r_ped_pending <= ped_req | (r_ped_pending & ~w_enter_fg);
            r_walk        <= w_walk_nxt;
            r_lights      <= lights_of(w_state_nxt, w_phase_nxt);
        end
    end

    assign hwy_light  = r_lights.hwy;
    assign farm_light = r_lights.farm;
    assign walk       = r_walk;
    assign state_o    = r_state;

endmodule

// File: doc/tlc_param_ctrl.md
Name: tlc_param_ctrl

Overview:
Parametrised two-road (highway/farm) traffic light controller, next generation of the single-sensor controller.
- Per-state down-counter timers with configurable durations and a clock prescaler.
- All-red clearance intervals, a latched pedestrian request with a walk output, and a flashing night/fault mode.
- Sits directly behind the tt_um top-level pin wrapper.

Parameters:
PRESCALE, 1, clk cycles per timer tick (>=1)
TW, 8, timer width in bits
HG_MIN_TICKS, 10, minimum highway green, ticks (>=1)
Y_TICKS, 3, yellow duration on either road, ticks (>=1)
AR_TICKS, 1, all-red clearance duration, ticks (>=1)
FG_TICKS, 10, farm green duration, ticks (>=1)
FLASH_TICKS, 1, ticks per flash half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  advance enable; low freezes all state, timers and prescaler
car_req  in  1  farm-road vehicle sensor, level or pulse
ped_req  in  1  pedestrian button, pulse
flash_en  in  1  night/fault flash mode request, level
hwy_light  out  3  highway {red,yellow,green}
farm_light  out  3  farm {red,yellow,green}
walk  out  1  pedestrian walk lamp
state_o  out  3  current state encoding, debug

Behaviour:
- One clock: clk. Reset is synchronous and active-low (rst_n), sampled on posedge clk. Reset has priority over ena.
- Reset values:
  - state=HG, hwy_light=001, farm_light=100, walk=0.
  - Timer=HG_MIN_TICKS-1, prescaler=0, req_pending=0, ped_pending=0, flash phase=0.
- Tick generation:
  - Prescaler counts 0..PRESCALE-1 while ena=1. Tick pulses when count==PRESCALE-1.
  - Prescaler clears to 0 on every state transition, so a state lasts exactly N*PRESCALE enabled cycles.
- Timers:
  - On entry to a state, the timer loads N-1, where N is that state's tick count.
  - Each tick: if timer!=0, decrement. If timer==0, evaluate the exit condition. When the exit condition is false, the timer holds at 0.
- States and transitions (lights listed hwy/farm):
  - HG (001/100): exits to HY on tick with timer==0 and (req_pending|ped_pending). Otherwise it dwells indefinitely.
  - HY (010/100): exits to AR1 after Y_TICKS.
  - AR1 (100/100): exits to FG after AR_TICKS.
  - FG (100/001): exits to FY after FG_TICKS. walk=ped_pending_at_entry for all of FG, 0 in every other state.
  - FY (100/010): exits to AR2 after Y_TICKS.
  - AR2 (100/100): exits to HG after AR_TICKS. HG re-entry loads HG_MIN_TICKS-1.
  - FLASH: hwy={0,phase,0}, farm={phase,0,0}. phase=1 on entry and toggles every FLASH_TICKS ticks.
- Flash mode:
  - flash_en=1 (and ena=1) in any non-FLASH state moves to FLASH on the next edge, regardless of timer.
  - In FLASH, flash_en=0 moves to AR2 on the next edge.
- Request latches:
  - car_req sets req_pending; ped_req sets ped_pending. Sets are accepted in any state.
  - Both pending flags clear on the edge entering FG; ped_pending is captured for walk on that same edge.
  - Simultaneous set and clear: set wins, so the request stays pending for the next cycle.
  - Entering FLASH does not clear the pending flags.
- ena=0: no state, timer, prescaler or phase change. Request latches still set.
- Outputs are registered or derived from registered state only. No combinational path from inputs to outputs.
- Invalid state encoding recovers to HG with HG reset values on the next edge.
- Elaboration check: any *_TICKS >= 2**TW or <1 is a fatal error.

Decomposition:
- tlc_pkg holds:
  - State enum HG=0, HY=1, AR1=2, FG=3, FY=4, AR2=5, FLASH=6.
  - Light constants RED=100, YEL=010, GRN=001, OFF=000.
- One sub-module, tlc_tick_gen: prescaler with inputs clk, rst_n, ena, clr; output tick.

Test Plan:
- Defaults, PRESCALE=1; reset, then 50 cycles with no inputs -> stays HG, hwy=001, farm=100, walk=0 throughout.
- car_req pulse at cycle 2 after reset -> HY at cycle 10, AR1 at 13, FG at 14, FY at 24, AR2 at 27, HG at 28. Next HY no earlier than cycle 38.
- ped_req pulse during HG with no car_req -> same sequence; walk=1 for exactly the 10 FG cycles. A car_req pulsed during FG re-triggers HY exactly 10 cycles after HG re-entry.
- flash_en raised mid-FG -> FLASH next cycle; farm/hwy alternate 100/010 and 000/000 every cycle. Drop flash_en -> AR2 for 1 cycle, then HG for a full 10-cycle minimum.
- rst_n low for one cycle mid-HY -> HG outputs on the next edge, pending flags cleared. ena held low for 5 cycles in HY -> HY lengthened by exactly 5 cycles.
- PRESCALE=4, Y_TICKS=3 build -> HY lasts exactly 12 cycles. Tick aligns to state entry, not to a free-running count.
